// File: rtl/sr_trace_monitor.sv
// Circular instruction-trace buffer with trigger, timeout and optional halt freeze.
// Define SR_TRACE_HALT_DETECT_EN to build in repeated-PC halt detection.
module sr_trace_monitor #(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT     = 300,
  parameter int STALL_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  input  logic                     clear,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [63:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              cycle_cnt,
  output logic [1:0]               state,
  output logic                     frozen
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN            = 2'b00,
    FROZEN_TRIG    = 2'b01,
    FROZEN_TIMEOUT = 2'b10,
    FROZEN_HALT    = 2'b11
  } state_e;

  state_e        cur_state, next_state;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_idx;
  logic          capture;
  logic          trig_hit;
  logic          halt_hit;
  logic          timeout_hit;

  assign capture     = (cur_state == RUN) && en && !clear;
  assign trig_hit    = capture && trig_en && (pc == trig_pc);
  assign timeout_hit = capture && ((cycle_cnt + 32'd1) == 32'(TIMEOUT));

`ifdef SR_TRACE_HALT_DETECT_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic [SW-1:0] stall_cnt;
  logic [31:0]   prev_pc;
  logic          prev_valid;
  logic          repeat_pc;

  // The first capture after reset/clear has no predecessor to repeat.
  assign repeat_pc = prev_valid && (pc == prev_pc);
  assign halt_hit  = capture && repeat_pc && ((stall_cnt + SW'(1)) == SW'(STALL_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      stall_cnt  <= '0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
    end else if (capture) begin
      stall_cnt  <= repeat_pc ? stall_cnt + SW'(1) : '0;
      prev_pc    <= pc;
      prev_valid <= 1'b1;
    end
  end
`else
  assign halt_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= RUN;
    else     cur_state <= next_state;
  end

  // NOTE: next_state gets a default before any branch so no latch is inferred.
  always_comb begin
    next_state = cur_state;
    if (clear) begin
      next_state = RUN;
    end else if (cur_state == RUN) begin
      if (trig_hit)         next_state = FROZEN_TRIG;
      else if (halt_hit)    next_state = FROZEN_HALT;
      else if (timeout_hit) next_state = FROZEN_TIMEOUT;
    end
  end

  always_comb begin
    state  = cur_state;
    frozen = (cur_state != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      count     <= '0;
      cycle_cnt <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      count     <= '0;
      cycle_cnt <= '0;
    end else if (capture) begin
      wr_ptr    <= wr_ptr + AW'(1);
      cycle_cnt <= cycle_cnt + 32'd1;
      if (count != (AW+1)'(DEPTH)) count <= count + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; reads beyond count are masked.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {pc, instr};
  end

  assign oldest = (count == (AW+1)'(DEPTH)) ? wr_ptr : '0;
  assign rd_idx = oldest + rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         rd_data <= '0;
    else if ({1'b0, rd_addr} < count) rd_data <= mem[rd_idx];
    else                             rd_data <= '0;
  end

endmodule

// File: tb/tb_sr_trace_monitor.sv
// Self-checking bench for sr_trace_monitor: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sr_trace_monitor;

  localparam int DEPTH       = 4;
  localparam int TIMEOUT     = 10;
  localparam int STALL_LIMIT = 4;
`ifdef SR_TRACE_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        clear = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [2:0]  count;
  logic [31:0] cycle_cnt;
  logic [1:0]  state;
  logic        frozen;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Reference model: list of stored entries, oldest first.
  logic [63:0] m_q[$];
  logic [31:0] m_cycles = '0;
  int          m_state = 0;
  int          m_rep = 0;
  bit          m_have_prev = 1'b0;
  logic [31:0] m_prev = '0;
  logic [63:0] exp_rd = '0;

  sr_trace_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .instr(instr),
    .trig_en(trig_en), .trig_pc(trig_pc), .clear(clear), .rd_addr(rd_addr),
    .rd_data(rd_data), .count(count), .cycle_cnt(cycle_cnt),
    .state(state), .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_cycles    = '0;
        m_state     = 0;
        m_rep       = 0;
        m_have_prev = 1'b0;
        exp_rd      = '0;
      end else begin
        if (int'(rd_addr) < m_q.size()) exp_rd = m_q[rd_addr];
        else                            exp_rd = '0;
        if (clear) begin
          m_q.delete();
          m_cycles    = '0;
          m_state     = 0;
          m_rep       = 0;
          m_have_prev = 1'b0;
        end else if (m_state == 0 && en) begin
          m_q.push_back({pc, instr});
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
          m_cycles = m_cycles + 32'd1;
          if (m_have_prev && pc == m_prev) m_rep++;
          else                             m_rep = 0;
          m_prev      = pc;
          m_have_prev = 1'b1;
          if (trig_en && pc == trig_pc)           m_state = 1;
          else if (HALT_EN && m_rep == STALL_LIMIT) m_state = 3;
          else if (m_cycles == 32'(TIMEOUT))      m_state = 2;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        check("state", 64'(state), 64'(m_state));
        check("frozen", 64'(frozen), 64'(m_state != 0));
        check("count", 64'(count), 64'(m_q.size()));
        check("cycle_cnt", 64'(cycle_cnt), 64'(m_cycles));
        check("rd_data", rd_data, exp_rd);
      end
    end
  end

  task automatic cyc(input logic e, input logic [31:0] p, input logic c, input logic [1:0] ra);
    en      = e;
    pc      = p;
    instr   = p * 32'd3 + 32'h1000_0001;
    clear   = c;
    rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] last_p = '0;
  logic [31:0] p_r;
  logic        c_r;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", 64'(state), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_rd", rd_data, 64'd0);

    // Three captures, then read every slot including one past count.
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0); cyc(1, 4, 0, 0); cyc(1, 8, 0, 0);
    check("cnt3", 64'(count), 64'd3);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 2'(k));
      if (k < 3) check("rd_partial", 64'(rd_data[63:32]), 64'(4 * k));
      else       check("rd_masked", rd_data, 64'd0);
    end

    // Six captures wrap a four-entry buffer.
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 6; k++) cyc(1, 32'(4 * k), 0, 0);
    check("cnt_wrap", 64'(count), 64'd4);
    cyc(0, 0, 0, 0); check("rd_oldest", 64'(rd_data[63:32]), 64'd8);
    cyc(0, 0, 0, 3); check("rd_newest", 64'(rd_data[63:32]), 64'd20);

    // Trigger on pc 0x0C; the following capture must be ignored.
    cyc(0, 0, 1, 0);
    trig_en = 1'b1; trig_pc = 32'h0C;
    cyc(1, 0, 0, 0); cyc(1, 4, 0, 0); cyc(1, 8, 0, 0); cyc(1, 32'h0C, 0, 0);
    check("trig_state", 64'(state), 64'd1);
    cyc(1, 32'h10, 0, 0);
    check("trig_hold", 64'(state), 64'd1);
    check("trig_cycles", 64'(cycle_cnt), 64'd4);
    check("trig_frozen", 64'(frozen), 64'd1);
    cyc(0, 0, 0, 3); check("trig_last", 64'(rd_data[63:32]), 64'h0C);
    trig_en = 1'b0;

    // Timeout after ten distinct captures, then clear.
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 12; k++) cyc(1, 32'h100 + 32'(4 * k), 0, 0);
    check("to_state", 64'(state), 64'd2);
    check("to_cycles", 64'(cycle_cnt), 64'd10);
    cyc(0, 0, 0, 3); check("to_last", 64'(rd_data[63:32]), 64'h124);
    cyc(0, 0, 1, 0);
    check("clr_state", 64'(state), 64'd0);
    check("clr_count", 64'(count), 64'd0);

    // Trigger wins over a simultaneous timeout.
    for (int k = 0; k < 9; k++) cyc(1, 32'h200 + 32'(4 * k), 0, 0);
    trig_en = 1'b1; trig_pc = 32'h300;
    cyc(1, 32'h300, 0, 0);
    check("prio_state", 64'(state), 64'd1);
    trig_en = 1'b0;

    // Repeated pc: halt when compiled in, otherwise timeout.
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0); cyc(1, 4, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 8, 0, 0);
    if (HALT_EN) begin
      check("halt_state", 64'(state), 64'd3);
      check("halt_cycles", 64'(cycle_cnt), 64'd7);
    end else begin
      check("nohalt_state", 64'(state), 64'd0);
      for (int k = 0; k < 3; k++) cyc(1, 8, 0, 0);
      check("nohalt_to", 64'(state), 64'd2);
      check("nohalt_cycles", 64'(cycle_cnt), 64'd10);
    end

    // Asynchronous reset between edges.
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0); cyc(1, 4, 0, 0); cyc(1, 8, 0, 0);
    check("pre_rst_count", 64'(count), 64'd3);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_count", 64'(count), 64'd0);
    check("async_state", 64'(state), 64'd0);
    check("async_cycles", 64'(cycle_cnt), 64'd0);
    check("async_rd", rd_data, 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    cyc(1, 32'h40, 0, 0);
    check("resume_count", 64'(count), 64'd1);
    cyc(0, 0, 0, 0); check("resume_rd", 64'(rd_data[63:32]), 64'h40);

    // Randomized phase against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        c_r = (m_state != 0) ? ($urandom_range(3) == 0) : ($urandom_range(39) == 0);
        p_r = ($urandom_range(1) == 1) ? last_p : 32'(4 * $urandom_range(7));
        last_p  = p_r;
        trig_en = ($urandom_range(3) == 0);
        trig_pc = 32'(4 * $urandom_range(7));
        en      = ($urandom_range(3) != 0);
        pc      = p_r;
        instr   = $urandom;
        clear   = c_r;
        rd_addr = 2'($urandom_range(3));
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_trace_monitor.md
SR_TRACE_MONITOR -- requirements
Module: sr_trace_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning trace buffer entries (power of two, >= 2).
REQ-002 SHALL have parameter TIMEOUT, default 300, meaning captures before timeout freeze (>= 1).
REQ-003 SHALL have parameter STALL_LIMIT, default 4, meaning consecutive repeated-PC captures that signal halt (>= 1).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  CPU step qualifier; capture only when high.
REQ-007 SHALL have port pc  input  32  PC of the instruction being traced.
REQ-008 SHALL have port instr  input  32  instruction word at pc.
REQ-009 SHALL have port trig_en  input  1  arms the PC-match trigger.
REQ-010 SHALL have port trig_pc  input  32  trigger PC.
REQ-011 SHALL have port clear  input  1  synchronous restart.
REQ-012 SHALL have port rd_addr  input  log2(DEPTH)  read index, 0 = oldest entry.
REQ-013 SHALL have port rd_data  output  64  {pc, instr} of selected entry, registered.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  number of valid entries.
REQ-015 SHALL have port cycle_cnt  output  32  captures since reset/clear.
REQ-016 SHALL have port state  output  2  00 RUN, 01 FROZEN_TRIG, 10 FROZEN_TIMEOUT, 11 FROZEN_HALT.
REQ-017 SHALL have port frozen  output  1  high in any FROZEN_* state.

Function
REQ-018 Capture SHALL occur on a cycle with state RUN, en=1, clear=0: write {pc, instr} at wr_ptr, wr_ptr+1 mod DEPTH, count+1 saturating at DEPTH, cycle_cnt+1 (wraps at 2^32).
REQ-019 Buffer SHALL be circular: once count=DEPTH, each capture overwrites the oldest entry.
REQ-020 Oldest index SHALL be wr_ptr when count=DEPTH, else 0; rd_data SHALL equal entry (oldest+rd_addr) mod DEPTH one cycle after rd_addr is presented.
REQ-021 rd_data SHALL be 0 when sampled rd_addr >= count; a same-cycle read and capture SHALL return pre-write contents.
REQ-022 Trigger: a capture with trig_en=1 and pc=trig_pc SHALL be stored, then state SHALL be FROZEN_TRIG next cycle.
REQ-023 Timeout: the capture that makes cycle_cnt equal TIMEOUT SHALL be stored, then state SHALL be FROZEN_TIMEOUT next cycle.
REQ-024 Simultaneous freeze causes SHALL resolve by priority trigger > halt > timeout.
REQ-025 In any FROZEN_* state buffer, wr_ptr, count, cycle_cnt SHALL hold; reads SHALL keep working; en ignored.
REQ-026 clear=1 in any state SHALL, next cycle, give state RUN, wr_ptr 0, count 0, cycle_cnt 0, stall counter 0; clear SHALL suppress any same-cycle capture or freeze.
REQ-027 frozen SHALL equal (state != RUN) combinationally.

Reset
REQ-028 rst=1 SHALL immediately force state RUN, wr_ptr 0, count 0, cycle_cnt 0, stall counter 0, rd_data 0, frozen 0, independent of clk.
REQ-029 Buffer storage contents SHALL not require reset; unwritten entries are masked by REQ-021.
REQ-030 Deassertion of rst mid-operation SHALL resume capture on the first rising edge with en=1.

Configuration
REQ-031 Macro SR_TRACE_HALT_DETECT_EN SHALL compile in halt detection: a stall counter increments on each capture whose pc equals the previously captured pc, resets to 0 otherwise; when it reaches STALL_LIMIT state SHALL be FROZEN_HALT next cycle.
REQ-032 Without SR_TRACE_HALT_DETECT_EN no stall counter or previous-PC register SHALL exist and state 11 SHALL never occur.

Verification
REQ-033 DEPTH=4, 3 captures pc=0,4,8 -> count=3, rd_addr 0..2 return pc 0,4,8; rd_addr 3 returns 0.
REQ-034 DEPTH=4, 6 captures pc=0..20 step 4 -> count=4, rd_addr 0 returns pc=8, rd_addr 3 returns pc=20.
REQ-035 trig_en=1, trig_pc=0x0C, pcs 0,4,8,0x0C,0x10 -> state=01 after pc 0x0C, cycle_cnt=4, pc 0x10 not stored.
REQ-036 TIMEOUT=5, free-running distinct pcs -> state=10, cycle_cnt=5; clear -> state=00, count=0 next cycle.
REQ-037 With SR_TRACE_HALT_DETECT_EN, STALL_LIMIT=4, pcs 0,4,8,8,8,8,8 -> state=11 after seventh capture; without macro timeout (TIMEOUT=10) fires instead.
REQ-038 rst asserted between clock edges during RUN with count=3 -> count=0, state=00 before the next edge.
